// File: rtl/buffer_arbiter.sv
// buffer_arbiter: owns the shared endpoint data buffer and sequences host, TX and RX access to it.
// Optional RX idle timeout is compiled in by defining BUF_ARB_RX_TIMEOUT_EN.
module buffer_arbiter #(
  parameter int DEPTH      = 64,
  parameter int RX_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       host_wr_req,
  input  logic       host_rd_req,
  input  logic       host_clear,
  input  logic       tx_start,
  input  logic       tx_byte_req,
  input  logic       tx_done,
  input  logic       rx_byte_valid,
  input  logic       rx_packet_done,
  input  logic       rx_error,
  output logic       host_ack,
  output logic       tx_byte_ack,
  output logic       buf_store_tx_data,
  output logic       buf_store_rx_packet_data,
  output logic       buf_get_tx_packet_data,
  output logic       buf_get_rx_data,
  output logic       buf_flush,
  output logic       buf_clear,
  output logic       rx_data_ready,
  output logic       tx_busy,
  output logic [6:0] byte_count,
  output logic       err_overflow,
  output logic       err_conflict,
  output logic       err_underrun
);

  typedef enum logic [2:0] {
    IDLE,
    HOST_FILL,
    TX_DRAIN,
    RX_FILL,
    RX_READY
  } state_t;

  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  state_t     state_reg, state_next;
  logic [6:0] count_reg, count_next;
  logic       overflow_reg, overflow_next;
  logic       conflict_reg, conflict_next;
  logic       underrun_reg, underrun_next;
  // Low through reset and the first cycle after release, so no event is accepted then.
  logic       run_reg;

`ifdef BUF_ARB_RX_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(RX_TIMEOUT - 1);
  logic [7:0] idle_cnt_reg, idle_cnt_next;
`else
  logic unused_cfg;
  assign unused_cfg = ^8'(RX_TIMEOUT);
`endif

  always_comb begin
    state_next               = state_reg;
    count_next               = count_reg;
    overflow_next            = overflow_reg;
    conflict_next            = conflict_reg;
    underrun_next            = underrun_reg;
    host_ack                 = 1'b0;
    tx_byte_ack              = 1'b0;
    buf_store_tx_data        = 1'b0;
    buf_store_rx_packet_data = 1'b0;
    buf_get_tx_packet_data   = 1'b0;
    buf_get_rx_data          = 1'b0;
    buf_flush                = 1'b0;
    buf_clear                = 1'b0;
`ifdef BUF_ARB_RX_TIMEOUT_EN
    idle_cnt_next            = 8'd0;
`endif
    if (run_reg) begin
      if (host_clear) begin
        buf_clear     = 1'b1;
        count_next    = 7'd0;
        state_next    = IDLE;
        overflow_next = 1'b0;
        conflict_next = 1'b0;
        underrun_next = 1'b0;
      end else if (rx_error && state_reg == RX_FILL) begin
        buf_flush  = 1'b1;
        count_next = 7'd0;
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rx_byte_valid) begin
              buf_store_rx_packet_data = 1'b1;
              count_next               = 7'd1;
              state_next               = RX_FILL;
            end else if (host_wr_req) begin
              buf_store_tx_data = 1'b1;
              host_ack          = 1'b1;
              count_next        = 7'd1;
              state_next        = HOST_FILL;
            end
          end
          HOST_FILL: begin
            if (rx_byte_valid) conflict_next = 1'b1;
            if (tx_start) begin
              state_next = TX_DRAIN;
            end else if (host_wr_req && count_reg < DEPTH_C) begin
              buf_store_tx_data = 1'b1;
              host_ack          = 1'b1;
              count_next        = count_reg + 7'd1;
            end
          end
          TX_DRAIN: begin
            if (rx_byte_valid) conflict_next = 1'b1;
            if (tx_done) begin
              buf_clear  = 1'b1;
              count_next = 7'd0;
              state_next = IDLE;
            end else if (tx_byte_req) begin
              if (count_reg != 7'd0) begin
                buf_get_tx_packet_data = 1'b1;
                tx_byte_ack            = 1'b1;
                count_next             = count_reg - 7'd1;
              end else begin
                underrun_next = 1'b1;
              end
            end
          end
          RX_FILL: begin
            if (rx_byte_valid) begin
              if (count_reg < DEPTH_C) begin
                buf_store_rx_packet_data = 1'b1;
                count_next               = count_reg + 7'd1;
              end else begin
                overflow_next = 1'b1;
              end
            end
            if (rx_packet_done) state_next = RX_READY;
`ifdef BUF_ARB_RX_TIMEOUT_EN
            // Silent cycles only; any byte leaves the counter at its reload value of 0.
            else if (!rx_byte_valid) begin
              if (idle_cnt_reg == TIMEOUT_LAST) begin
                buf_flush  = 1'b1;
                count_next = 7'd0;
                state_next = IDLE;
              end else begin
                idle_cnt_next = idle_cnt_reg + 8'd1;
              end
            end
`endif
          end
          RX_READY: begin
            if (rx_byte_valid) conflict_next = 1'b1;
            if (host_rd_req && count_reg != 7'd0) begin
              buf_get_rx_data = 1'b1;
              host_ack        = 1'b1;
              count_next      = count_reg - 7'd1;
              if (count_reg == 7'd1) state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= IDLE;
      count_reg    <= 7'd0;
      overflow_reg <= 1'b0;
      conflict_reg <= 1'b0;
      underrun_reg <= 1'b0;
      run_reg      <= 1'b0;
`ifdef BUF_ARB_RX_TIMEOUT_EN
      idle_cnt_reg <= 8'd0;
`endif
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      conflict_reg <= conflict_next;
      underrun_reg <= underrun_next;
      run_reg      <= 1'b1;
`ifdef BUF_ARB_RX_TIMEOUT_EN
      idle_cnt_reg <= idle_cnt_next;
`endif
    end
  end

  assign rx_data_ready = (state_reg == RX_READY);
  assign tx_busy       = (state_reg == TX_DRAIN);
  assign byte_count    = count_reg;
  assign err_overflow  = overflow_reg;
  assign err_conflict  = conflict_reg;
  assign err_underrun  = underrun_reg;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Scoreboard bench for buffer_arbiter: stimulus queues expected strobe/ack sets, a negedge monitor checks them.
module tb_buffer_arbiter;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic host_wr_req = 1'b0, host_rd_req = 1'b0, host_clear = 1'b0;
  logic tx_start = 1'b0, tx_byte_req = 1'b0, tx_done = 1'b0;
  logic rx_byte_valid = 1'b0, rx_packet_done = 1'b0, rx_error = 1'b0;
  logic host_ack, tx_byte_ack;
  logic buf_store_tx_data, buf_store_rx_packet_data, buf_get_tx_packet_data, buf_get_rx_data;
  logic buf_flush, buf_clear, rx_data_ready, tx_busy;
  logic [6:0] byte_count;
  logic err_overflow, err_conflict, err_underrun;

  buffer_arbiter dut (
    .clk(clk), .n_rst(n_rst),
    .host_wr_req(host_wr_req), .host_rd_req(host_rd_req), .host_clear(host_clear),
    .tx_start(tx_start), .tx_byte_req(tx_byte_req), .tx_done(tx_done),
    .rx_byte_valid(rx_byte_valid), .rx_packet_done(rx_packet_done), .rx_error(rx_error),
    .host_ack(host_ack), .tx_byte_ack(tx_byte_ack),
    .buf_store_tx_data(buf_store_tx_data), .buf_store_rx_packet_data(buf_store_rx_packet_data),
    .buf_get_tx_packet_data(buf_get_tx_packet_data), .buf_get_rx_data(buf_get_rx_data),
    .buf_flush(buf_flush), .buf_clear(buf_clear),
    .rx_data_ready(rx_data_ready), .tx_busy(tx_busy), .byte_count(byte_count),
    .err_overflow(err_overflow), .err_conflict(err_conflict), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  // strobe/ack set bits
  localparam logic [7:0] HACK = 8'h80, TACK = 8'h40, STX = 8'h20, SRX = 8'h10;
  localparam logic [7:0] GTX = 8'h08, GRX = 8'h04, FL = 8'h02, CL = 8'h01;
  // event bits
  localparam logic [8:0] E_WR = 9'h100, E_RD = 9'h080, E_CLR = 9'h040, E_TXS = 9'h020;
  localparam logic [8:0] E_TXR = 9'h010, E_TXD = 9'h008, E_RXV = 9'h004, E_RXD = 9'h002;
  localparam logic [8:0] E_RXE = 9'h001, E_NONE = 9'h000;

  int checks = 0;
  int failures = 0;
  logic [14:0] sb_q[$];
  logic [14:0] mon_exp;

  wire [7:0] strb = {host_ack, tx_byte_ack, buf_store_tx_data, buf_store_rx_packet_data,
                     buf_get_tx_packet_data, buf_get_rx_data, buf_flush, buf_clear};
  wire [19:0] all_out = {strb, rx_data_ready, tx_busy, byte_count,
                         err_overflow, err_conflict, err_underrun};

  // Monitor: every cycle with a strobe or ack must match the next queued expectation.
  always @(negedge clk) begin
    if (n_rst && strb != 8'h00) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got strb=%h count=%0d, required no strobe", strb, byte_count);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({strb, byte_count} != mon_exp) begin
          failures++;
          $display("FAIL strobe_set: got strb=%h count=%0d, required strb=%h count=%0d",
                   strb, byte_count, mon_exp[14:7], mon_exp[6:0]);
        end else begin
          $display("txn strb=%h count=%0d ok", strb, byte_count);
        end
      end
    end
  end

  task automatic set_events(input logic [8:0] ev);
    {host_wr_req, host_rd_req, host_clear, tx_start, tx_byte_req, tx_done,
     rx_byte_valid, rx_packet_done, rx_error} = ev;
  endtask

  task automatic step(input logic [8:0] ev, input logic [7:0] exp_s, input logic [6:0] exp_c);
    set_events(ev);
    if (exp_s != 8'h00) sb_q.push_back({exp_s, exp_c});
    @(posedge clk);
    #1;
    set_events(E_NONE);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("chk %s = %0d ok", name, act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset: outputs stay 0 during reset and the first cycle after release
    set_events(E_WR | E_RXV | E_TXR);
    #12;
    chk("outputs_in_reset", int'(all_out), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    #2;
    chk("outputs_first_cycle", int'(all_out), 0);
    @(posedge clk);
    #1;
    set_events(E_NONE);
    chk("count_after_reset", int'(byte_count), 0);
    chk("state_after_reset", int'({rx_data_ready, tx_busy}), 0);

    // host fill then TX drain
    step(E_WR, HACK | STX, 7'd0);
    step(E_WR, HACK | STX, 7'd1);
    step(E_WR, HACK | STX, 7'd2);
    chk("host_fill_count", int'(byte_count), 3);
    step(E_TXS, 8'h00, 7'd0);
    chk("tx_busy_drain", int'(tx_busy), 1);
    step(E_TXR, TACK | GTX, 7'd3);
    step(E_TXR, TACK | GTX, 7'd2);
    step(E_TXR, TACK | GTX, 7'd1);
    step(E_TXD, CL, 7'd0);
    chk("tx_done_count", int'(byte_count), 0);
    chk("tx_done_idle", int'({rx_data_ready, tx_busy}), 0);

    // 65 RX bytes: last one overflows
    step(E_RXV, SRX, 7'd0);
    for (int i = 1; i < 64; i++) step(E_RXV, SRX, 7'(i));
    chk("rx_full_count", int'(byte_count), 64);
    step(E_RXV, 8'h00, 7'd0);
    chk("rx_overflow_flag", int'(err_overflow), 1);
    chk("rx_overflow_count", int'(byte_count), 64);
    step(E_RXD, 8'h00, 7'd0);
    chk("rx_data_ready", int'(rx_data_ready), 1);
    for (int i = 64; i >= 1; i--) step(E_RD, HACK | GRX, 7'(i));
    chk("rx_drained_ready", int'(rx_data_ready), 0);
    chk("overflow_sticky", int'(err_overflow), 1);
    step(E_CLR, CL, 7'd0);
    chk("overflow_cleared", int'(err_overflow), 0);

    // RX_READY with count 2, host_rd_req held three cycles
    step(E_RXV, SRX, 7'd0);
    step(E_RXV, SRX, 7'd1);
    step(E_RXD, 8'h00, 7'd0);
    step(E_RD, HACK | GRX, 7'd2);
    step(E_RD, HACK | GRX, 7'd1);
    step(E_RD, 8'h00, 7'd0);
    chk("rd2_ready", int'(rx_data_ready), 0);
    chk("rd2_count", int'(byte_count), 0);

    // simultaneous RX and host write in IDLE: RX wins
    step(E_RXV | E_WR, SRX, 7'd0);
    chk("race_count", int'(byte_count), 1);
    step(E_RXE, FL, 7'd1);
    chk("rx_error_count", int'(byte_count), 0);
    step(E_WR, HACK | STX, 7'd0);
    step(E_RXV, 8'h00, 7'd0);
    chk("conflict_flag", int'(err_conflict), 1);
    chk("conflict_count", int'(byte_count), 1);
    step(E_CLR, CL, 7'd1);
    chk("conflict_cleared", int'(err_conflict), 0);

    // RX_FILL with count 5 then rx_error
    for (int i = 0; i < 5; i++) step(E_RXV, SRX, 7'(i));
    step(E_RXE, FL, 7'd5);
    chk("flush5_count", int'(byte_count), 0);
    step(E_WR, HACK | STX, 7'd0);
    step(E_CLR, CL, 7'd1);

    // silent RX_FILL
    step(E_RXV, SRX, 7'd0);
    step(E_RXV, SRX, 7'd1);
    step(E_RXV, SRX, 7'd2);
`ifdef BUF_ARB_RX_TIMEOUT_EN
    repeat (254) step(E_NONE, 8'h00, 7'd0);
    chk("pre_timeout_count", int'(byte_count), 3);
    step(E_NONE, FL, 7'd3);
    chk("timeout_count", int'(byte_count), 0);
`else
    repeat (300) step(E_NONE, 8'h00, 7'd0);
    chk("no_timeout_count", int'(byte_count), 3);
    step(E_RXE, FL, 7'd3);
    chk("rx_error_after_wait", int'(byte_count), 0);
`endif

    // TX underrun, then host_clear
    step(E_WR, HACK | STX, 7'd0);
    step(E_TXS, 8'h00, 7'd0);
    step(E_TXR, TACK | GTX, 7'd1);
    step(E_TXR, 8'h00, 7'd0);
    chk("underrun_flag", int'(err_underrun), 1);
    chk("underrun_busy", int'(tx_busy), 1);
    step(E_CLR, CL, 7'd0);
    chk("underrun_cleared", int'(err_underrun), 0);
    chk("clear_idle", int'(tx_busy), 0);
    step(E_WR, HACK | STX, 7'd0);
    step(E_CLR, CL, 7'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/buffer_arbiter.md
# buffer_arbiter

- Sequences the shared 64-byte endpoint data buffer between the host-side register interface and the USB TX/RX engines.
- Owns the buffer direction, and issues every store, get, flush and clear strobe to the buffer.
- Keeps its own byte count, so it does not depend on the buffer's registered occupancy.
- Arbitrates simultaneous host and USB requests, with USB always taking priority.

## Interface
- DEPTH, 64: buffer capacity in bytes.
- RX_TIMEOUT, 255: idle-cycle limit in RX_FILL (used only with the timeout feature).
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- host_wr_req  in  1  host offers one TX payload byte; held until host_ack.
- host_rd_req  in  1  host requests one RX payload byte; held until host_ack.
- host_clear  in  1  host abort and clear.
- tx_start  in  1  pulse: host payload complete, start transmission.
- tx_byte_req  in  1  TX encoder wants the next byte.
- tx_done  in  1  pulse: TX encoder finished the packet.
- rx_byte_valid  in  1  pulse: RX decoder has one byte.
- rx_packet_done  in  1  pulse: RX packet ended cleanly.
- rx_error  in  1  pulse: RX packet corrupt.
- host_ack  out  1  host request accepted this cycle.
- tx_byte_ack  out  1  TX byte fetched this cycle.
- buf_store_tx_data, buf_store_rx_packet_data, buf_get_tx_packet_data, buf_get_rx_data, buf_flush, buf_clear  out  1 each  buffer strobes.
- rx_data_ready  out  1  RX packet waiting for the host.
- tx_busy  out  1  buffer owned by TX_DRAIN.
- byte_count  out  7  internal occupancy, 0..DEPTH.
- err_overflow, err_conflict, err_underrun  out  1 each  sticky error flags.

## Operation
- States: IDLE, HOST_FILL, TX_DRAIN, RX_FILL, RX_READY.
- Priority in every state: host_clear > rx_error > all other events.
  - host_clear: buf_clear=1, count goes to 0, state goes to IDLE, sticky errors clear.
- IDLE (count=0):
  - rx_byte_valid: store RX, go to RX_FILL.
  - Otherwise, host_wr_req: store TX, host_ack, go to HOST_FILL.
  - When both occur in the same cycle, RX wins and host_ack stays 0.
- HOST_FILL:
  - host_wr_req with count<DEPTH: store, ack.
  - host_wr_req with count==DEPTH: no ack, request stays pending.
  - tx_start: go to TX_DRAIN.
- TX_DRAIN:
  - tx_byte_req with count>0: buf_get_tx_packet_data, tx_byte_ack, decrement count.
  - tx_byte_req with count==0: no ack, err_underrun set.
  - tx_done: buf_clear, count goes to 0, go to IDLE.
- RX_FILL:
  - rx_byte_valid with count<DEPTH: store, increment count.
  - rx_byte_valid with count==DEPTH: byte dropped, err_overflow set.
  - rx_packet_done: go to RX_READY.
  - rx_error: buf_flush, count goes to 0, go to IDLE.
- RX_READY (rx_data_ready=1):
  - host_rd_req with count>0: buf_get_rx_data, host_ack, decrement count.
  - The read that takes count from 1 to 0 moves the state to IDLE.
- Any request not listed for the current state is ignored (no strobe, no ack).
  - Exception: rx_byte_valid outside IDLE/RX_FILL drops the byte and sets err_conflict.
- Strobes are mutually exclusive; at most one buffer strobe per cycle.

## Timing
- Reset: state IDLE, count 0.
  - Every output is 0 while n_rst=0 and in the first cycle after release.
- Strobes and acks are Mealy outputs: combinational from registered state and current inputs.
  - Each strobe or ack is asserted in the same cycle as the accepted event (zero latency).
  - The buffer captures the strobe on the next rising edge.
- State, count and sticky flags update on the rising edge after the event.
- Count rules:
  - Count saturates at DEPTH and never wraps below 0.
  - A store and a get in the same cycle are impossible by construction.
- Flag rules:
  - rx_data_ready and tx_busy are Moore outputs (from state only).
  - Sticky flags clear only on reset or host_clear.
- Reset mid-operation: immediate return to IDLE. No flush strobe is issued; the buffer is reset by the same n_rst.

## Configuration
- BUF_ARB_RX_TIMEOUT_EN defined:
  - An 8-bit idle counter runs in RX_FILL and reloads on each rx_byte_valid.
  - If it reaches RX_TIMEOUT cycles without rx_byte_valid, rx_packet_done or rx_error: buf_flush, count goes to 0, err_overflow unchanged, go to IDLE.
- BUF_ARB_RX_TIMEOUT_EN undefined: no counter; RX_FILL waits indefinitely.

## Test plan
- Reset, 3 host writes, tx_start, 3 tx_byte_req, tx_done:
  - 3 host_ack pulses, then 3 tx_byte_ack pulses.
  - buf_clear pulses once, count returns 3 -> 0, state IDLE.
- 65 rx_byte_valid pulses:
  - First 64 raise buf_store_rx_packet_data, count reaches 64.
  - 65th raises no strobe and sets err_overflow=1.
  - Then rx_packet_done gives rx_data_ready=1.
- RX_READY with count=2, hold host_rd_req:
  - 2 host_ack and 2 buf_get_rx_data pulses.
  - State IDLE, rx_data_ready=0.
- IDLE, rx_byte_valid and host_wr_req in the same cycle:
  - buf_store_rx_packet_data=1, host_ack=0, state RX_FILL.
  - A later rx_byte_valid during HOST_FILL sets err_conflict.
- RX_FILL with count=5, rx_error:
  - buf_flush pulses, count 0, state IDLE.
  - With BUF_ARB_RX_TIMEOUT_EN, 255 silent cycles produce the same result.
- TX_DRAIN with count=0, tx_byte_req: no ack, err_underrun=1.
  - host_clear then clears err_underrun and returns the state to IDLE.
